// File: rtl/lshift16_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : lshift16_iter_if
// Description : Request/result bundle for lshift16_iter; the rot signal exists
//               only when LSHIFT16_ROTATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lshift16_iter_if;
    logic        start;
    logic [15:0] A;
    logic [3:0]  shl;
`ifdef LSHIFT16_ROTATE_EN
    logic        rot;
`endif
    logic [15:0] OUT;
    logic        busy;
    logic        done;

`ifdef LSHIFT16_ROTATE_EN
    modport master (output start, A, shl, rot, input OUT, busy, done);
    modport slave  (input start, A, shl, rot, output OUT, busy, done);
`else
    modport master (output start, A, shl, input OUT, busy, done);
    modport slave  (input start, A, shl, output OUT, busy, done);
`endif
endinterface : lshift16_iter_if
`default_nettype wire

// File: rtl/lshift16_iter.sv
`default_nettype none
// ============================================================================
// Module      : lshift16_iter
// Description : One-bit-per-cycle 16-bit left shifter with start/busy/done
//               handshake. Define LSHIFT16_ROTATE_EN to add circular rotate.
// Revision    : 1.0 - initial release
// ============================================================================
module lshift16_iter (
    input  wire               clk,
    input  wire               reset,
    lshift16_iter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] out_q,   out_d;
    logic        w_fill;

`ifdef LSHIFT16_ROTATE_EN
    logic        rot_q, rot_d;

    assign w_fill = rot_q & out_q[15];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rot_q <= 1'b0;
        else       rot_q <= rot_d;
    end
`else
    assign w_fill = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            out_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        out_d   = out_q;
`ifdef LSHIFT16_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            // IDLE and DONE both accept a new request, giving back-to-back issue
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    out_d   = bus.A;
                    count_d = bus.shl;
`ifdef LSHIFT16_ROTATE_EN
                    rot_d   = bus.rot;
`endif
                    state_d = (bus.shl != 4'd0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                out_d   = {out_q[14:0], w_fill};
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.OUT  = out_q;
    assign bus.busy = (state_q == S_SHIFT);
    assign bus.done = (state_q == S_DONE);

endmodule : lshift16_iter
`default_nettype wire

// File: tb/tb_lshift16_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lshift16_iter
// Description : Self-checking bench for lshift16_iter against a shift/rotate
//               reference computed from plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lshift16_iter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    lshift16_iter_if bus ();

    lshift16_iter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Expected value after n single-bit steps of shifting/rotating a
    function automatic logic [15:0] ref_result(input logic [15:0] a, input int n, input bit r);
        logic [31:0] wide;
        logic [15:0] res;
        wide = {16'h0000, a} << n;
        res  = wide[15:0];
        if (r && n != 0) res = res | (a >> (16 - n));
        return res;
    endfunction

    task automatic drive_req(input logic [15:0] a, input logic [3:0] n, input bit r);
        bus.start = 1'b1;
        bus.A     = a;
        bus.shl   = n;
`ifdef LSHIFT16_ROTATE_EN
        bus.rot   = r;
`endif
    endtask

    // Called #1 after an edge; issues the request on the next edge and follows it
    // through its DONE cycle. glitch > 0 raises a competing start sampled at that edge.
    task automatic run_op(input logic [15:0] a, input logic [3:0] n, input bit r, input int glitch);
        int nn;
        nn = int'(n);
        drive_req(a, n, r);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k <= nn; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            check("busy", {15'd0, bus.busy}, {15'd0, k < nn});
            check("done", {15'd0, bus.done}, {15'd0, k == nn});
            check(k == nn ? "result" : "partial", bus.OUT, ref_result(a, k, r));
            if (glitch > 0 && k + 1 == glitch) drive_req(16'hFFFF, 4'd3, 1'b0);
        end
    endtask

    task automatic idle_cycle(input logic [15:0] held);
        @(posedge clk); #1;
        check("idle_busy", {15'd0, bus.busy}, 16'd0);
        check("idle_done", {15'd0, bus.done}, 16'd0);
        check("idle_out",  bus.OUT, held);
    endtask

    initial begin
        logic [15:0] ra;
        logic [3:0]  rn;
        bit          rr;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.shl   = 4'd0;
`ifdef LSHIFT16_ROTATE_EN
        bus.rot   = 1'b0;
`endif
        #1;
        check("rst_out",  bus.OUT, 16'h0000);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_done", {15'd0, bus.done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'hA5C3, 4'd0, 1'b0, 0);
        idle_cycle(16'hA5C3);
        run_op(16'h1234, 4'd4, 1'b0, 0);
        check("basic_1234", bus.OUT, 16'h2340);
        idle_cycle(16'h2340);
        run_op(16'h8001, 4'd15, 1'b0, 0);
        check("shl15", bus.OUT, 16'h8000);
        idle_cycle(16'h8000);

        run_op(16'h00FF, 4'd8, 1'b0, 3);
        check("ignored_start", bus.OUT, 16'hFF00);
        // Back-to-back: issue straight from the DONE cycle above
        run_op(16'h0001, 4'd1, 1'b0, 0);
        check("b2b", bus.OUT, 16'h0002);
        idle_cycle(16'h0002);

`ifdef LSHIFT16_ROTATE_EN
        run_op(16'h8001, 4'd1, 1'b1, 0);
        check("rot_8001", bus.OUT, 16'h0003);
        run_op(16'hF00F, 4'd4, 1'b1, 0);
        check("rot_F00F", bus.OUT, 16'h00FF);
        idle_cycle(16'h00FF);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rn = 4'($urandom_range(0, 15));
`ifdef LSHIFT16_ROTATE_EN
            rr = bit'($urandom_range(0, 1));
`else
            rr = 1'b0;
`endif
            run_op(ra, rn, rr, 0);
            if ($urandom_range(0, 1) == 0) idle_cycle(ref_result(ra, int'(rn), rr));
        end

        // Reset in the middle of a shift aborts with no done pulse
        drive_req(16'hFFFF, 4'd8, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out",  bus.OUT, 16'h0000);
        check("midrst_busy", {15'd0, bus.busy}, 16'd0);
        check("midrst_done", {15'd0, bus.done}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("midrst_nodone", {15'd0, bus.done}, 16'd0);
        end
        check("midrst_out_after", bus.OUT, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lshift16_iter
`default_nettype wire
